// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the ID-stage hazard controller: hazard classification codes,
// controller FSM states and the sizing rule for the stall-cycle counter.
package hazard_ctrl_unit_pkg;

    typedef enum logic [1:0] {
        HZ_NONE     = 2'd0,
        HZ_LOAD_USE = 2'd1,
        HZ_BR_ALU   = 2'd2,
        HZ_BR_LOAD  = 2'd3
    } hz_kind_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    localparam int NUM_HZ_SRC = 4;

    // Wide enough to hold the longest stall, LOAD_LAT+1 (branch behind a load in EX).
    function automatic int stall_cnt_w(input int load_lat);
        return $clog2(load_lat + 2);
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_match.sv
// Combinational hazard detector: works out how many stall cycles the instruction in ID
// needs and which hazard class caused it.
module hazard_match
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int RW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_HW  = 1,
    parameter int NW       = 2
) (
    input  logic [RW-1:0] rs_id,
    input  logic [RW-1:0] rt_id,
    input  logic          use_rs_id,
    input  logic          use_rt_id,
    input  logic          branch_id,
    input  logic [RW-1:0] rd_ex,
    input  logic          reg_write_ex,
    input  logic          mem_read_ex,
    input  logic [RW-1:0] rd_mem,
    input  logic          mem_read_mem,
    output logic [NW-1:0] n_req,
    output hz_kind_t      kind_req
);

    logic [RW-1:0] src_reg [2];
    logic [1:0]    src_match;

    assign src_reg[0] = rd_ex;
    assign src_reg[1] = rd_mem;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic zero_gated;
            assign zero_gated     = (ZERO_HW != 0) && (src_reg[gi] == '0);
            assign src_match[gi]  = !zero_gated &&
                                    (((src_reg[gi] == rs_id) && use_rs_id) ||
                                     ((src_reg[gi] == rt_id) && use_rt_id));
        end
    endgenerate

    // Candidates are ordered by non-decreasing kind code so a later hit wins a tie.
    logic [NUM_HZ_SRC-1:0] cand_hit;
    logic [NW-1:0]         cand_n    [NUM_HZ_SRC];
    hz_kind_t              cand_kind [NUM_HZ_SRC];

    assign cand_hit[0]  = mem_read_ex && src_match[0];
    assign cand_n[0]    = NW'(LOAD_LAT);
    assign cand_kind[0] = HZ_LOAD_USE;

    assign cand_hit[1]  = branch_id && reg_write_ex && !mem_read_ex && src_match[0];
    assign cand_n[1]    = NW'(1);
    assign cand_kind[1] = HZ_BR_ALU;

    assign cand_hit[2]  = branch_id && mem_read_ex && src_match[0];
    assign cand_n[2]    = NW'(LOAD_LAT + 1);
    assign cand_kind[2] = HZ_BR_LOAD;

    assign cand_hit[3]  = branch_id && mem_read_mem && src_match[1];
    assign cand_n[3]    = NW'(LOAD_LAT);
    assign cand_kind[3] = HZ_BR_LOAD;

    always_comb begin
        n_req    = '0;
        kind_req = HZ_NONE;
        for (int i = 0; i < NUM_HZ_SRC; i++) begin
            if (cand_hit[i] && (cand_n[i] >= n_req)) begin
                n_req    = cand_n[i];
                kind_req = cand_kind[i];
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ID-stage hazard controller: holds PC and IF/ID and bubbles ID/EX for the required
// number of cycles, honours flush and memory-busy freeze, and counts stall cycles.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int RW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    parameter int ZERO_HW  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RW-1:0]    rs_id,
    input  logic [RW-1:0]    rt_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic             branch_id,
    input  logic [RW-1:0]    rd_ex,
    input  logic             reg_write_ex,
    input  logic             mem_read_ex,
    input  logic [RW-1:0]    rd_mem,
    input  logic             mem_read_mem,
    input  logic             flush,
    input  logic             mem_busy,
    input  logic             perf_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic             stall_active,
    output logic [1:0]       hazard_kind,
    output logic [CNT_W-1:0] perf_stall_cnt
);

    localparam int NW = stall_cnt_w(LOAD_LAT);

    state_t          state_reg, state_next;
    logic [NW-1:0]   rem_reg, rem_next;
    hz_kind_t        kind_reg, kind_next;
    logic [CNT_W-1:0] perf_reg;

    logic [NW-1:0]   n_req;
    hz_kind_t        kind_req;

    hazard_match #(
        .RW       (RW),
        .LOAD_LAT (LOAD_LAT),
        .ZERO_HW  (ZERO_HW),
        .NW       (NW)
    ) u_match (
        .rs_id        (rs_id),
        .rt_id        (rt_id),
        .use_rs_id    (use_rs_id),
        .use_rt_id    (use_rt_id),
        .branch_id    (branch_id),
        .rd_ex        (rd_ex),
        .reg_write_ex (reg_write_ex),
        .mem_read_ex  (mem_read_ex),
        .rd_mem       (rd_mem),
        .mem_read_mem (mem_read_mem),
        .n_req        (n_req),
        .kind_req     (kind_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            rem_reg   <= '0;
            kind_reg  <= HZ_NONE;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            kind_reg  <= kind_next;
        end
    end

    // Freeze holds everything; flush cancels any stall in progress.
    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        kind_next  = kind_reg;
        if (mem_busy) begin
            state_next = state_reg;
        end else if (flush) begin
            state_next = ST_RUN;
            rem_next   = '0;
            kind_next  = HZ_NONE;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (n_req > NW'(1)) begin
                        state_next = ST_STALL;
                        rem_next   = n_req - NW'(1);
                        kind_next  = kind_req;
                    end
                end
                ST_STALL: begin
                    rem_next = rem_reg - NW'(1);
                    if (rem_reg == NW'(1)) begin
                        state_next = ST_RUN;
                        kind_next  = HZ_NONE;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                    rem_next   = '0;
                    kind_next  = HZ_NONE;
                end
            endcase
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_bubble  = 1'b0;
        pipe_freeze  = 1'b0;
        stall_active = 1'b0;
        hazard_kind  = HZ_NONE;
        if (mem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            pipe_freeze = 1'b1;
            if (state_reg == ST_STALL) begin
                hazard_kind = kind_reg;
            end
        end else if (flush) begin
            idex_bubble = 1'b1;
        end else if (state_reg == ST_STALL) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
            stall_active = 1'b1;
            hazard_kind  = kind_reg;
        end else if (n_req != '0) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
            stall_active = 1'b1;
            hazard_kind  = kind_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_reg <= '0;
        end else if (perf_clr) begin
            perf_reg <= '0;
        end else if (stall_active && (perf_reg != '1)) begin
            perf_reg <= perf_reg + CNT_W'(1);
        end
    end

    assign perf_stall_cnt = perf_reg;

endmodule
